ieee_to_fpu_conv: RTL
=====================

Name: ieee_to_fpu_conv

Overview:
- Multi-cycle operand encoder. Converts IEEE-754 binary32 values into the FPU's custom 32-bit format: sign[31], exponent[30:24] (7 bits, bias 63), mantissa[23:0] (24 bits, hidden 1 when exp≠0).
- Status uses the FPU's one-hot code.
- Sits in front of the fpu adder operand ports and is the write side of the custom format the adder consumes.

Parameters:
- EXP_BIAS, 63, custom exponent bias; custom_exp = ieee_exp − 127 + EXP_BIAS.
- MAX_NORM_EXP, 126, largest legal custom exponent; 127 is reserved as overflow, as the adder treats it.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_data  in  32  IEEE-754 binary32 operand
- in_valid  in  1  operand present
- in_ready  out  1  high only in IDLE
- data_out  out  32  custom-format result
- status_out  out  4  one-hot: 0001 exact, 0010 inexact, 0100 overflow, 1000 underflow
- out_valid  out  1  result valid; held until out_ready

Behaviour:
- Reset (reset low, any state, including mid-SHIFT): state IDLE, data_out=0, status_out=0, out_valid=0, all internal registers cleared. in_ready=(state==IDLE). in_data is ignored while reset is low.
- FSM states: IDLE, CLASSIFY, SHIFT, ROUND, DONE.
- IDLE: on in_valid&in_ready, latch in_data. Next state CLASSIFY.
- CLASSIFY (e = ieee exponent, m = 23-bit fraction):
  - e=0, m=0: result {sign,31'b0}, status exact → DONE.
  - e=0, m≠0 (IEEE subnormal, below custom range): data 0, status underflow → DONE.
  - e>MAX_NORM_EXP+127−EXP_BIAS (190), including Inf/NaN: data 0, status overflow → DONE.
  - 65≤e≤190: {sign, e−64, m,1'b0}, status exact → DONE.
  - e≤64: custom exp 0, working mantissa = {1,m}, s = 64−e.
    - s=0: result exact → DONE.
    - 1≤s≤25: load shift counter = s → SHIFT.
    - s>25: data 0, status underflow → DONE.
- SHIFT: one right shift per cycle. The bit shifted out of bit 0 goes into guard; the previous guard ORs into sticky. Counter decrements; at 1 → ROUND.
- ROUND: round-to-nearest-even. Increment if guard&(sticky|lsb). inexact = guard|sticky.
  - Increment carries to 2^24: exp=1, mantissa=0 (smallest normal).
  - Rounded mantissa 0 (input was nonzero): data 0, status underflow.
  - Otherwise status inexact or exact. Sign preserved.
  - → DONE.
- DONE: out_valid=1; data_out/status_out stable. On out_ready → IDLE and out_valid drops next cycle. No accept in the DONE cycle (no bypass).
- Status priority: overflow > underflow > inexact > exact. Exactly one bit is set whenever out_valid=1.
- Latency, counting edges from the accept edge to out_valid high:
  - direct cases: 2
  - shift cases: 3+s
  - extra DONE cycles under back-pressure.

Decomposition:
- Package fpu_pkg holds:
  - widths EXP_W=7, MAN_W=24, constant EXP_BIAS
  - status constants ST_EXACT, ST_INEXACT, ST_OVERFLOW, ST_UNDERFLOW
  - conv state enum
  - the fpu adder imports the same status constants.
- No sub-module; rounding is inline in ROUND.

Test Plan:
- 0x3F800000 (1.0) → data 0x3F000000, status 0001, out_valid 2 edges after accept.
- 0xC0200000 (−2.5) → 0xC0400000, status 0001.
- 0x71800000 (2^100) and 0x7F800000 (+Inf) → data 0x00000000, status 0100. 0x80000000 → 0x80000000, status 0001.
- Subnormal path:
  - 0x1F800000 (2^−64) → 0x00400000, status 0001, latency 4.
  - 0x1F800001 (tie, even) → 0x00400000, status 0010.
  - 0x1F800003 (tie, odd) → 0x00400002, status 0010.
- 0x0D800000 (2^−100, s=37) → 0x00000000, status 1000.
- Back-pressure: out_ready low 5 cycles → out_valid, data_out, status_out stable and in_ready=0; then out_ready=1 → in_ready=1 next cycle.
- Reset mid-operation: reset pulsed during SHIFT of 0x1F800003 → all outputs 0, state IDLE, next operand converts correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// fpu_pkg -- widths, one-hot status codes and encoder state type shared by the FPU front end (rev 1.0).
package fpu_pkg;

  localparam int EXP_W    = 7;
  localparam int MAN_W    = 24;
  localparam int EXP_BIAS = 63;
  localparam int STATUS_W = 4;

  // Status is one-hot; the adder decodes the same constants.
  localparam logic [STATUS_W-1:0] ST_EXACT     = 4'b0001;
  localparam logic [STATUS_W-1:0] ST_INEXACT   = 4'b0010;
  localparam logic [STATUS_W-1:0] ST_OVERFLOW  = 4'b0100;
  localparam logic [STATUS_W-1:0] ST_UNDERFLOW = 4'b1000;

  typedef enum logic [2:0] {
    CONV_IDLE,
    CONV_CLASSIFY,
    CONV_SHIFT,
    CONV_ROUND,
    CONV_DONE
  } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/ieee_to_fpu_conv_if.sv
`default_nettype none
// ieee_to_fpu_conv_if -- operand-in / result-out handshake bundle for the IEEE-to-custom encoder (rev 1.0).
interface ieee_to_fpu_conv_if;
  import fpu_pkg::*;

  logic [31:0]         in_data;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         data_out;
  logic [STATUS_W-1:0] status_out;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, data_out, status_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, data_out, status_out, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/ieee_to_fpu_conv.sv
`default_nettype none
// ieee_to_fpu_conv -- multi-cycle IEEE binary32 to FPU custom format encoder with
// round-to-nearest-even on values that fall below the custom normal range (rev 1.0).
module ieee_to_fpu_conv #(
  parameter int EXP_BIAS     = fpu_pkg::EXP_BIAS,
  parameter int MAX_NORM_EXP = 126
) (
  input  logic              clk,
  input  logic              reset,
  ieee_to_fpu_conv_if.slave bus
);
  import fpu_pkg::*;

  // IEEE exponent that maps to custom exponent 0, and the largest one still in range.
  localparam logic [7:0] LOW_E     = 8'(127 - EXP_BIAS);
  localparam logic [7:0] HI_E      = 8'(MAX_NORM_EXP + 127 - EXP_BIAS);
  localparam logic [7:0] MAX_SHIFT = 8'(MAN_W + 1);

  conv_state_t         state;
  logic [31:0]         operand;
  logic [MAN_W-1:0]    mant;
  logic                guard;
  logic                sticky;
  logic [4:0]          cnt;
  logic [31:0]         data_q;
  logic [STATUS_W-1:0] status_q;
  logic                valid_q;

  logic [7:0]       op_exp;
  logic [22:0]      op_frac;
  logic [EXP_W-1:0] norm_exp;
  logic [7:0]       sub_shift;
  logic             round_up;
  logic             inexact;
  logic [MAN_W:0]   rounded;

  assign op_exp    = operand[30:23];
  assign op_frac   = operand[22:0];
  assign norm_exp  = EXP_W'(op_exp - LOW_E);
  assign sub_shift = LOW_E - op_exp;

  assign round_up = guard & (sticky | mant[0]);
  assign inexact  = guard | sticky;
  assign rounded  = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};

  assign bus.in_ready   = (state == CONV_IDLE);
  assign bus.data_out   = data_q;
  assign bus.status_out = status_q;
  assign bus.out_valid  = valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CONV_IDLE;
      operand  <= '0;
      mant     <= '0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      cnt      <= '0;
      data_q   <= '0;
      status_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (bus.in_valid) begin
            operand <= bus.in_data;
            state   <= CONV_CLASSIFY;
          end
        end

        CONV_CLASSIFY: begin
          state   <= CONV_DONE;
          valid_q <= 1'b1;
          if (op_exp == 8'd0) begin
            if (op_frac == 23'd0) begin
              data_q   <= {operand[31], 31'd0};
              status_q <= ST_EXACT;
            end else begin
              data_q   <= '0;
              status_q <= ST_UNDERFLOW;
            end
          end else if (op_exp > HI_E) begin
            data_q   <= '0;
            status_q <= ST_OVERFLOW;
          end else if (op_exp > LOW_E) begin
            data_q   <= {operand[31], norm_exp, op_frac, 1'b0};
            status_q <= ST_EXACT;
          end else if (sub_shift == 8'd0) begin
            data_q   <= {operand[31], {EXP_W{1'b0}}, 1'b1, op_frac};
            status_q <= ST_EXACT;
          end else if (sub_shift > MAX_SHIFT) begin
            data_q   <= '0;
            status_q <= ST_UNDERFLOW;
          end else begin
            // Denormalise with the hidden one made explicit, one bit per cycle.
            mant    <= {1'b1, op_frac};
            guard   <= 1'b0;
            sticky  <= 1'b0;
            cnt     <= sub_shift[4:0];
            state   <= CONV_SHIFT;
            valid_q <= 1'b0;
          end
        end

        CONV_SHIFT: begin
          mant   <= mant >> 1;
          guard  <= mant[0];
          sticky <= sticky | guard;
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= CONV_ROUND;
          end
        end

        CONV_ROUND: begin
          state   <= CONV_DONE;
          valid_q <= 1'b1;
          if (rounded[MAN_W]) begin
            data_q   <= {operand[31], EXP_W'(1), MAN_W'(0)};
            status_q <= inexact ? ST_INEXACT : ST_EXACT;
          end else if (rounded[MAN_W-1:0] == '0) begin
            data_q   <= '0;
            status_q <= ST_UNDERFLOW;
          end else begin
            data_q   <= {operand[31], {EXP_W{1'b0}}, rounded[MAN_W-1:0]};
            status_q <= inexact ? ST_INEXACT : ST_EXACT;
          end
        end

        CONV_DONE: begin
          if (bus.out_ready) begin
            state   <= CONV_IDLE;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state   <= CONV_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
